ddr_rd_arbiter: RTL and testbench

//  Shares one DDR read master port between REQ_NUM rotate/read cells. Latches each cell's one-cycle

---
 rtl/ddr_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_rd_arbiter: round-robin share of one DDR read port among REQ_NUM cells  |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ddr_rd_arbiter #(
  parameter int REQ_NUM    = 4,
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 32,
  parameter int TO_WIDTH   = 16
) (
  input  logic                          ddr_clk,
  input  logic                          ddr_rst,
  input  logic [REQ_NUM-1:0]            req_rreq,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_raddr,
  input  logic [REQ_NUM*LEN_WIDTH-1:0]  req_rd_len,
  input  logic [REQ_NUM-1:0]            req_ban,
  output logic [REQ_NUM-1:0]            req_rdata_en,
  output logic [REQ_NUM-1:0]            req_rdone,
  output logic [8*DQ_WIDTH-1:0]         req_rdata,
  output logic                          ddr_rreq,
  output logic [ADDR_WIDTH-1:0]         ddr_raddr,
  output logic [LEN_WIDTH-1:0]          ddr_rd_len,
  input  logic                          ddr_rrdy,
  input  logic [8*DQ_WIDTH-1:0]         ddr_rdata,
  input  logic                          ddr_rdata_en,
  input  logic                          ddr_rdone,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [REQ_NUM-1:0]            overrun_err,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(REQ_NUM);
  localparam logic [TO_WIDTH-1:0] WD_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [REQ_NUM-1:0]    pend, elig, clr, grant_oh;
  logic [ADDR_WIDTH-1:0] addr_q [REQ_NUM];
  logic [LEN_WIDTH-1:0]  len_q  [REQ_NUM];
  logic [IDX_W-1:0]      grant, last_grant, pick;
  logic                  pick_vld;
  logic [TO_WIDTH-1:0]   wd;
  logic                  accept, wd_expire;
  int                    d, best;

  assign elig      = pend & ~req_ban;
  assign grant_oh  = REQ_NUM'(1) << grant;
  assign clr       = (accept || wd_expire) ? grant_oh : '0;
  assign req_rdata = ddr_rdata;
  assign busy      = (state != IDLE);
  assign grant_id  = 3'(grant);

  // Round-robin: the eligible cell with the smallest distance past last_grant wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    best     = REQ_NUM;
    d        = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      d = (i + REQ_NUM - 1 - int'(last_grant)) % REQ_NUM;
      if (elig[i] && d < best) begin
        best     = d;
        pick     = IDX_W'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ddr_rreq     = 1'b0;
    req_rdata_en = '0;
    req_rdone    = '0;
    accept       = 1'b0;
    wd_expire    = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = ISSUE;
      ISSUE: begin
        ddr_rreq = 1'b1;
        if (ddr_rrdy) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end else if (wd == WD_LAST) begin
          wd_expire = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (ddr_rdata_en) req_rdata_en = grant_oh;
        if (ddr_rdone) begin
          req_rdone = grant_oh;
          state_nxt = IDLE;
        end else if (wd == WD_LAST) begin
          wd_expire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new request beats a same-cycle clear, so an accepted cell can re-queue at once.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      pend        <= '0;
      overrun_err <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (req_rreq[i] && (!pend[i] || clr[i])) begin
          pend[i]   <= 1'b1;
          addr_q[i] <= req_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          len_q[i]  <= req_rd_len[i*LEN_WIDTH +: LEN_WIDTH];
        end else if (req_rreq[i]) begin
          overrun_err[i] <= 1'b1;
        end else if (clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      grant       <= '0;
      last_grant  <= IDX_W'(REQ_NUM - 1);
      ddr_raddr   <= '0;
      ddr_rd_len  <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant      <= pick;
        ddr_raddr  <= addr_q[pick];
        ddr_rd_len <= len_q[pick];
      end
      if (accept)    last_grant  <= grant;
      if (wd_expire) timeout_err <= 1'b1;
      if (state_nxt != state)  wd <= '0;
      else if (state != IDLE)  wd <= wd + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_arbiter.sv
`default_nettype none
// Bench for ddr_rd_arbiter: per-cycle comparison against a queue/array model plus directed literal checks.
module tb_ddr_rd_arbiter;
  localparam int N = 4, AW = 27, LW = 16, DW = 32, TW = 8;
  localparam int LIMIT = (1 << TW) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0]      req_rreq = '0, req_ban = '0;
  logic [N*AW-1:0]   req_raddr = '0;
  logic [N*LW-1:0]   req_rd_len = '0;
  logic [N-1:0]      req_rdata_en, req_rdone, overrun_err;
  logic [8*DW-1:0]   req_rdata;
  logic              ddr_rreq, busy, timeout_err;
  logic [AW-1:0]     ddr_raddr;
  logic [LW-1:0]     ddr_rd_len;
  logic              ddr_rrdy = 1'b0, ddr_rdata_en = 1'b0, ddr_rdone = 1'b0;
  logic [8*DW-1:0]   ddr_rdata = '0;
  logic [2:0]        grant_id;

  ddr_rd_arbiter #(.REQ_NUM(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DW), .TO_WIDTH(TW)) dut (
    .ddr_clk(clk), .ddr_rst(rst), .req_rreq(req_rreq), .req_raddr(req_raddr),
    .req_rd_len(req_rd_len), .req_ban(req_ban), .req_rdata_en(req_rdata_en),
    .req_rdone(req_rdone), .req_rdata(req_rdata), .ddr_rreq(ddr_rreq),
    .ddr_raddr(ddr_raddr), .ddr_rd_len(ddr_rd_len), .ddr_rrdy(ddr_rrdy),
    .ddr_rdata(ddr_rdata), .ddr_rdata_en(ddr_rdata_en), .ddr_rdone(ddr_rdone),
    .grant_id(grant_id), .busy(busy), .overrun_err(overrun_err), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: phase 0=idle, 1=request offered, 2=data phase
  bit          started = 0;
  bit          m_pend [N];
  logic [AW-1:0] m_addr [N];
  logic [LW-1:0] m_len  [N];
  logic [N-1:0]  m_ovr, clr_v;
  bit          m_to;
  int          m_phase, m_owner, m_last, m_spent, c;
  logic [AW-1:0] m_raddr;
  logic [LW-1:0] m_rlen;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_ovr = '0; m_to = 0; m_phase = 0; m_owner = 0; m_last = N - 1;
      m_spent = 0; m_raddr = '0; m_rlen = '0;
    end else begin
      clr_v = '0;
      case (m_phase)
        0: for (int off = 1; off <= N; off++) begin
             c = (m_last + off) % N;
             if (m_phase == 0 && m_pend[c] && !req_ban[c]) begin
               m_owner = c; m_raddr = m_addr[c]; m_rlen = m_len[c];
               m_phase = 1; m_spent = 0;
             end
           end
        1: if (ddr_rrdy) begin
             clr_v[m_owner] = 1'b1; m_last = m_owner; m_phase = 2; m_spent = 0;
           end else begin
             m_spent++;
             if (m_spent == LIMIT) begin m_to = 1; clr_v[m_owner] = 1'b1; m_phase = 0; end
           end
        default: if (ddr_rdone) m_phase = 0;
           else begin
             m_spent++;
             if (m_spent == LIMIT) begin m_to = 1; clr_v[m_owner] = 1'b1; m_phase = 0; end
           end
      endcase
      for (int i = 0; i < N; i++) begin
        if (req_rreq[i]) begin
          if (!m_pend[i] || clr_v[i]) begin
            m_pend[i] = 1; m_addr[i] = req_raddr[i*AW +: AW]; m_len[i] = req_rd_len[i*LW +: LW];
          end else m_ovr[i] = 1'b1;
        end else if (clr_v[i]) m_pend[i] = 0;
      end
    end
  end

  int   acc_id [$];
  logic [AW-1:0] acc_addr [$];
  int   strobe_cnt [N], done_cnt [N];
  logic [N-1:0] own;

  always @(negedge clk) begin
    if (started) begin
      own = N'(1) << m_owner;
      chk("busy", busy, m_phase != 0);
      chk("ddr_rreq", ddr_rreq, m_phase == 1);
      chk("grant_id", grant_id, 3'(m_owner));
      chk("ddr_raddr", ddr_raddr, m_raddr);
      chk("ddr_rd_len", ddr_rd_len, m_rlen);
      chk("req_rdata_en", req_rdata_en, (m_phase == 2 && ddr_rdata_en) ? own : '0);
      chk("req_rdone", req_rdone, (m_phase == 2 && ddr_rdone) ? own : '0);
      chk("req_rdata", req_rdata, ddr_rdata);
      chk("overrun_err", overrun_err, m_ovr);
      chk("timeout_err", timeout_err, m_to);
      if (ddr_rreq && ddr_rrdy && !rst) begin
        acc_id.push_back(int'(grant_id));
        acc_addr.push_back(ddr_raddr);
      end
      for (int i = 0; i < N; i++) begin
        if (req_rdata_en[i]) strobe_cnt[i]++;
        if (req_rdone[i])    done_cnt[i]++;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    acc_id.delete(); acc_addr.delete();
    for (int i = 0; i < N; i++) begin strobe_cnt[i] = 0; done_cnt[i] = 0; end
  endtask
  task automatic pulse(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_rreq[id] = 1'b1;
    req_raddr[id*AW +: AW] = a;
    req_rd_len[id*LW +: LW] = l;
  endtask
  task automatic fire(); tick(); req_rreq = '0; endtask
  task automatic wait_rreq();
    int n = 0;
    while (!ddr_rreq && n < 40) begin tick(); n++; end
    if (!ddr_rreq) chk("wait_rreq_timeout", 1'b0, 1'b1);
  endtask
  task automatic serve(input int len, input int hold);
    wait_rreq();
    repeat (hold) tick();
    ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
    for (int b = 0; b < len; b++) begin
      ddr_rdata_en = 1'b1; ddr_rdata = {8{$urandom}}; tick();
    end
    ddr_rdata_en = 1'b0;
    ddr_rdone = 1'b1; tick(); ddr_rdone = 1'b0;
  endtask
  function automatic int pop_id();
    if (acc_id.size() == 0) return -1;
    return acc_id.pop_front();
  endfunction

  initial begin
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 3'd0);
    chk("rst_errs", {overrun_err, timeout_err}, '0);

    // single burst
    pulse(2, 27'h1000, 16'd64); fire();
    chk("t1_lat_t1", ddr_rreq, 1'b0);
    tick();
    chk("t1_lat_t2", ddr_rreq, 1'b1);
    chk("t1_raddr", ddr_raddr, 27'h1000);
    chk("t1_len", ddr_rd_len, 16'd64);
    serve(64, 0); tick();
    chk("t1_strobes2", strobe_cnt[2], 64);
    chk("t1_strobes_other", strobe_cnt[0] + strobe_cnt[1] + strobe_cnt[3], 0);
    chk("t1_done2", done_cnt[2], 1);
    chk("t1_grant", grant_id, 3'd2);
    chk("t1_acc", pop_id(), 2);

    // round robin, two rounds
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) pulse(i, 27'(32'h100 * (i + 1)), 16'd3);
      fire();
      repeat (N) serve(3, 0);
      for (int i = 0; i < N; i++) chk("t2_rr_order", pop_id(), i);
    end

    // ban skips cell 0
    do_reset();
    req_ban = 4'b0001;
    pulse(0, 27'h500, 16'd2); pulse(1, 27'h600, 16'd2); fire();
    serve(2, 0);
    req_ban = '0;
    serve(2, 0);
    chk("t3_first", pop_id(), 1);
    chk("t3_second", pop_id(), 0);

    // backpressure
    do_reset();
    pulse(3, 27'h3333, 16'd4); fire();
    serve(4, 10); repeat (3) tick();
    chk("t4_one_accept", acc_id.size(), 1);
    chk("t4_id", pop_id(), 3);
    chk("t4_idle", busy, 1'b0);

    // overrun keeps first capture
    do_reset();
    req_ban = 4'b0010;
    pulse(1, 27'hAAA, 16'd8); fire();
    pulse(1, 27'hBBB, 16'd9); fire();
    chk("t5_overrun", overrun_err, 4'b0010);
    req_ban = '0;
    serve(2, 0);
    chk("t5_id", pop_id(), 1);
    chk("t5_addr", (acc_addr.size() > 0) ? acc_addr.pop_front() : 27'h0, 27'hAAA);

    // watchdog in data phase
    do_reset();
    pulse(0, 27'h40, 16'd4); fire();
    wait_rreq();
    ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
    repeat (LIMIT - 1) tick();
    chk("t6_busy_before", busy, 1'b1);
    chk("t6_to_before", timeout_err, 1'b0);
    tick();
    chk("t6_busy_after", busy, 1'b0);
    chk("t6_to_after", timeout_err, 1'b1);
    ddr_rdone = 1'b1; ddr_rdata_en = 1'b1; #1;
    chk("t6_idle_rdone", req_rdone, '0);
    chk("t6_idle_rdata_en", req_rdata_en, '0);
    tick(); ddr_rdone = 1'b0; ddr_rdata_en = 1'b0;

    // reset in the middle of a burst drops everything
    pulse(2, 27'h222, 16'd8); pulse(3, 27'h333, 16'd8); fire();
    wait_rreq();
    ddr_rrdy = 1'b1; tick(); ddr_rrdy = 1'b0;
    repeat (3) begin ddr_rdata_en = 1'b1; tick(); end
    ddr_rdata_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_errs", {overrun_err, timeout_err}, '0);
    repeat (5) tick();
    chk("t6_rst_no_pending", ddr_rreq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
